// File: rtl/mix_columns_serial.sv
// Column-serial AES MixColumns / InvMixColumns over one 128-bit State.
// Handles COLS_PER_CYCLE columns per cycle with a valid/ready handshake on both sides.
module mix_columns_serial #(
    parameter int COLS_PER_CYCLE = 1
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [127:0] in_data,
    input  logic         in_inv,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [127:0] out_data,
    output logic         busy
);

    generate
        if (!(COLS_PER_CYCLE == 1 || COLS_PER_CYCLE == 2 || COLS_PER_CYCLE == 4)) begin : g_bad_cols
            $error("mix_columns_serial: COLS_PER_CYCLE must be 1, 2 or 4");
        end
    endgenerate

    // With 4 columns per cycle the step truncates to 0, so col simply stays at 0.
    localparam logic [1:0] STEP     = 2'(COLS_PER_CYCLE);
    localparam logic [1:0] LAST_COL = 2'(4 - COLS_PER_CYCLE);

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    state_t       state;
    logic [1:0]   col;
    logic [127:0] word;
    logic         inv;
    logic [127:0] result;
    logic [127:0] next_result;
    logic         started;
    logic [1:0]   idx;

    function automatic logic [7:0] xtime(input logic [7:0] b);
        return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
    endfunction

    function automatic logic [31:0] mix_column(input logic [31:0] c, input logic inv_mode);
        logic [7:0] s  [4];
        logic [7:0] x2 [4];
        logic [7:0] x4 [4];
        logic [7:0] x8 [4];
        logic [31:0] r;
        r = '0;
        for (int i = 0; i < 4; i++) begin
            s[i]  = c[8*i +: 8];
            x2[i] = xtime(s[i]);
            x4[i] = xtime(x2[i]);
            x8[i] = xtime(x4[i]);
        end
        // Row r uses coefficients rotated right by r: fwd {2,3,1,1}, inv {e,b,d,9}.
        for (int i = 0; i < 4; i++) begin
            if (!inv_mode)
                r[8*i +: 8] = x2[i] ^ (x2[(i+1)%4] ^ s[(i+1)%4]) ^ s[(i+2)%4] ^ s[(i+3)%4];
            else
                r[8*i +: 8] = (x8[i] ^ x4[i] ^ x2[i])
                            ^ (x8[(i+1)%4] ^ x2[(i+1)%4] ^ s[(i+1)%4])
                            ^ (x8[(i+2)%4] ^ x4[(i+2)%4] ^ s[(i+2)%4])
                            ^ (x8[(i+3)%4] ^ s[(i+3)%4]);
        end
        return r;
    endfunction

    always_comb begin
        next_result = result;
        idx         = '0;
        for (int k = 0; k < COLS_PER_CYCLE; k++) begin
            idx = col + 2'(k);
            next_result[32*idx +: 32] = mix_column(word[32*idx +: 32], inv);
        end
    end

    // started keeps in_ready low until the first edge after reset release.
    assign in_ready  = started && ((state == IDLE) || ((state == DONE) && out_ready));
    assign out_valid = (state == DONE);
    assign busy      = (state != IDLE);
    assign out_data  = result;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state   <= IDLE;
            col     <= '0;
            word    <= '0;
            inv     <= 1'b0;
            result  <= '0;
            started <= 1'b0;
        end else begin
            started <= 1'b1;
            case (state)
                IDLE: begin
                    if (in_valid && in_ready) begin
                        word  <= in_data;
                        inv   <= in_inv;
                        col   <= '0;
                        state <= RUN;
                    end
                end
                RUN: begin
                    result <= next_result;
                    col    <= col + STEP;
                    if (col == LAST_COL)
                        state <= DONE;
                end
                DONE: begin
                    if (out_ready) begin
                        if (in_valid) begin
                            word  <= in_data;
                            inv   <= in_inv;
                            col   <= '0;
                            state <= RUN;
                        end else begin
                            state <= IDLE;
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_mix_columns_serial.sv
// Directed and randomized bench for mix_columns_serial at 1, 2 and 4 columns per cycle.
module tb_mix_columns_serial;

    logic         clk = 1'b0;
    logic         rst_n;
    logic         in_valid  [3];
    logic         in_inv    [3];
    logic         out_ready [3];
    logic [127:0] in_data   [3];
    logic         in_ready  [3];
    logic         out_valid [3];
    logic         busy      [3];
    logic [127:0] out_data  [3];

    int vectors = 0;
    int errors  = 0;

    always #5 clk = ~clk;

    for (genvar g = 0; g < 3; g++) begin : g_dut
        mix_columns_serial #(.COLS_PER_CYCLE(1 << g)) dut (
            .clk       (clk),
            .rst_n     (rst_n),
            .in_valid  (in_valid[g]),
            .in_ready  (in_ready[g]),
            .in_data   (in_data[g]),
            .in_inv    (in_inv[g]),
            .out_valid (out_valid[g]),
            .out_ready (out_ready[g]),
            .out_data  (out_data[g]),
            .busy      (busy[g])
        );
    end

    function automatic logic [31:0] col4(input logic [7:0] s0, s1, s2, s3);
        return {s3, s2, s1, s0};
    endfunction

    function automatic logic [127:0] rand128();
        return {$urandom(), $urandom(), $urandom(), $urandom()};
    endfunction

    // Reference: plain shift-and-add GF(2^8) multiply and matrix product.
    function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p;
        logic       hi;
        p = 8'h00;
        for (int i = 0; i < 8; i++) begin
            if (b[0]) p = p ^ a;
            hi = a[7];
            a  = a << 1;
            if (hi) a = a ^ 8'h1b;
            b  = b >> 1;
        end
        return p;
    endfunction

    function automatic logic [127:0] ref_word(input logic [127:0] w, input logic inv);
        logic [7:0]   cf [4];
        logic [7:0]   acc;
        logic [127:0] o;
        if (!inv) begin
            cf[0] = 8'h02; cf[1] = 8'h03; cf[2] = 8'h01; cf[3] = 8'h01;
        end else begin
            cf[0] = 8'h0e; cf[1] = 8'h0b; cf[2] = 8'h0d; cf[3] = 8'h09;
        end
        o = '0;
        for (int c = 0; c < 4; c++)
            for (int r = 0; r < 4; r++) begin
                acc = 8'h00;
                for (int j = 0; j < 4; j++)
                    acc = acc ^ gmul(w[32*c + 8*j +: 8], cf[(j - r + 4) % 4]);
                o[32*c + 8*r +: 8] = acc;
            end
        return o;
    endfunction

    task automatic idle_all();
        for (int i = 0; i < 3; i++) begin
            in_valid[i]  = 1'b0;
            in_inv[i]    = 1'b0;
            out_ready[i] = 1'b0;
            in_data[i]   = '0;
        end
    endtask

    // Sends one word from IDLE, checks latency and data, then drains it.
    task automatic run_word(input int d, input logic [127:0] w, input logic inv,
                            input int exp_lat, input logic [127:0] exp, input string name);
        int lat;
        @(posedge clk); #1;
        in_valid[d] = 1'b1; in_data[d] = w; in_inv[d] = inv;
        @(posedge clk); #1;
        in_valid[d] = 1'b0; in_data[d] = ~w; in_inv[d] = ~inv;
        lat = 0;
        while (!out_valid[d] && lat < 20) begin
            @(posedge clk); #1;
            lat++;
        end
        vectors++;
        if (lat !== exp_lat) begin
            errors++;
            $display("FAIL %s_latency dut%0d: got %0d edges, want %0d", name, d, lat, exp_lat);
        end
        vectors++;
        if (out_data[d] !== exp) begin
            errors++;
            $display("FAIL %s_data dut%0d: got %h want %h", name, d, out_data[d], exp);
        end
        out_ready[d] = 1'b1;
        @(posedge clk); #1;
        out_ready[d] = 1'b0;
        vectors++;
        if (out_valid[d] !== 1'b0 || busy[d] !== 1'b0) begin
            errors++;
            $display("FAIL %s_release dut%0d: got valid=%b busy=%b want 0 0", name, d, out_valid[d], busy[d]);
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        idle_all();
        #12;
        for (int i = 0; i < 3; i++) begin
            vectors++;
            if (out_valid[i] !== 1'b0 || busy[i] !== 1'b0 || in_ready[i] !== 1'b0 || out_data[i] !== '0) begin
                errors++;
                $display("FAIL reset_state dut%0d: got valid=%b busy=%b ready=%b data=%h want 0 0 0 0",
                         i, out_valid[i], busy[i], in_ready[i], out_data[i]);
            end
        end
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        vectors++;
        if (in_ready[0] !== 1'b0) begin
            errors++;
            $display("FAIL ready_before_edge: got %b want 0", in_ready[0]);
        end
        @(posedge clk); #1;
        for (int i = 0; i < 3; i++) begin
            vectors++;
            if (in_ready[i] !== 1'b1) begin
                errors++;
                $display("FAIL ready_after_edge dut%0d: got %b want 1", i, in_ready[i]);
            end
        end
    endtask

    task automatic test_forward();
        logic [127:0] w, e;
        w = {col4(8'h01, 8'h01, 8'h01, 8'h01), col4(8'h01, 8'h01, 8'h01, 8'h01),
             col4(8'h01, 8'h01, 8'h01, 8'h01), col4(8'hdb, 8'h13, 8'h53, 8'h45)};
        e = {col4(8'h01, 8'h01, 8'h01, 8'h01), col4(8'h01, 8'h01, 8'h01, 8'h01),
             col4(8'h01, 8'h01, 8'h01, 8'h01), col4(8'h8e, 8'h4d, 8'ha1, 8'hbc)};
        run_word(0, w, 1'b0, 4, e, "fwd");
    endtask

    task automatic test_inverse();
        logic [127:0] w, e, c6;
        w = {col4(8'h01, 8'h01, 8'h01, 8'h01), col4(8'h01, 8'h01, 8'h01, 8'h01),
             col4(8'h01, 8'h01, 8'h01, 8'h01), col4(8'h8e, 8'h4d, 8'ha1, 8'hbc)};
        e = {col4(8'h01, 8'h01, 8'h01, 8'h01), col4(8'h01, 8'h01, 8'h01, 8'h01),
             col4(8'h01, 8'h01, 8'h01, 8'h01), col4(8'hdb, 8'h13, 8'h53, 8'h45)};
        run_word(0, w, 1'b1, 4, e, "inv");
        c6 = {16{8'hc6}};
        run_word(0, c6, 1'b0, 4, c6, "c6_fwd");
        run_word(0, c6, 1'b1, 4, c6, "c6_inv");
    endtask

    task automatic test_all_widths();
        logic [127:0] w, e;
        w = {col4(8'h01, 8'h01, 8'h01, 8'h01), col4(8'h2d, 8'h26, 8'h31, 8'h4c),
             col4(8'hd4, 8'hd4, 8'hd4, 8'hd5), col4(8'hf2, 8'h0a, 8'h22, 8'h5c)};
        e = {col4(8'h01, 8'h01, 8'h01, 8'h01), col4(8'h4d, 8'h7e, 8'hbd, 8'hf8),
             col4(8'hd5, 8'hd5, 8'hd7, 8'hd6), col4(8'h9f, 8'hdc, 8'h58, 8'h9d)};
        run_word(0, w, 1'b0, 4, e, "vec_c1");
        run_word(1, w, 1'b0, 2, e, "vec_c2");
        run_word(2, w, 1'b0, 1, e, "vec_c4");
        run_word(1, e, 1'b1, 2, w, "vec_inv_c2");
        run_word(2, e, 1'b1, 1, w, "vec_inv_c4");
    endtask

    task automatic test_backpressure();
        logic [127:0] w1, e1, w2, e2;
        int lat;
        w1 = {col4(8'h01, 8'h01, 8'h01, 8'h01), col4(8'h2d, 8'h26, 8'h31, 8'h4c),
              col4(8'hd4, 8'hd4, 8'hd4, 8'hd5), col4(8'hf2, 8'h0a, 8'h22, 8'h5c)};
        e1 = {col4(8'h01, 8'h01, 8'h01, 8'h01), col4(8'h4d, 8'h7e, 8'hbd, 8'hf8),
              col4(8'hd5, 8'hd5, 8'hd7, 8'hd6), col4(8'h9f, 8'hdc, 8'h58, 8'h9d)};
        w2 = {col4(8'hc6, 8'hc6, 8'hc6, 8'hc6), col4(8'h01, 8'h01, 8'h01, 8'h01),
              col4(8'h01, 8'h01, 8'h01, 8'h01), col4(8'hdb, 8'h13, 8'h53, 8'h45)};
        e2 = {col4(8'hc6, 8'hc6, 8'hc6, 8'hc6), col4(8'h01, 8'h01, 8'h01, 8'h01),
              col4(8'h01, 8'h01, 8'h01, 8'h01), col4(8'h8e, 8'h4d, 8'ha1, 8'hbc)};
        @(posedge clk); #1;
        in_valid[0] = 1'b1; in_data[0] = w1; in_inv[0] = 1'b0;
        @(posedge clk); #1;
        in_valid[0] = 1'b0;
        lat = 0;
        while (!out_valid[0] && lat < 20) begin
            @(posedge clk); #1;
            lat++;
        end
        for (int i = 0; i < 10; i++) begin
            @(posedge clk); #1;
            vectors++;
            if (out_valid[0] !== 1'b1 || in_ready[0] !== 1'b0 || out_data[0] !== e1) begin
                errors++;
                $display("FAIL hold_cycle%0d: got valid=%b ready=%b data=%h want 1 0 %h",
                         i, out_valid[0], in_ready[0], out_data[0], e1);
            end
        end
        out_ready[0] = 1'b1; in_valid[0] = 1'b1; in_data[0] = w2; in_inv[0] = 1'b0;
        #1;
        vectors++;
        if (in_ready[0] !== 1'b1) begin
            errors++;
            $display("FAIL done_ready: got %b want 1", in_ready[0]);
        end
        @(posedge clk); #1;
        out_ready[0] = 1'b0; in_valid[0] = 1'b0; in_data[0] = '0; in_inv[0] = 1'b1;
        vectors++;
        if (out_valid[0] !== 1'b0 || busy[0] !== 1'b1) begin
            errors++;
            $display("FAIL no_bubble: got valid=%b busy=%b want 0 1", out_valid[0], busy[0]);
        end
        lat = 0;
        while (!out_valid[0] && lat < 20) begin
            @(posedge clk); #1;
            lat++;
        end
        vectors++;
        if (lat !== 4 || out_data[0] !== e2) begin
            errors++;
            $display("FAIL back_to_back: got lat=%0d data=%h want 4 %h", lat, out_data[0], e2);
        end
        out_ready[0] = 1'b1;
        @(posedge clk); #1;
        out_ready[0] = 1'b0;
    endtask

    task automatic test_reset_mid_run();
        logic seen;
        @(posedge clk); #1;
        in_valid[0] = 1'b1; in_data[0] = {16{8'h5a}}; in_inv[0] = 1'b0;
        @(posedge clk); #1;
        in_valid[0] = 1'b0;
        @(posedge clk);
        @(posedge clk); #1;
        rst_n = 1'b0;
        #1;
        vectors++;
        if (out_valid[0] !== 1'b0 || out_data[0] !== '0 || busy[0] !== 1'b0 || in_ready[0] !== 1'b0) begin
            errors++;
            $display("FAIL mid_run_reset: got valid=%b data=%h busy=%b ready=%b want 0 0 0 0",
                     out_valid[0], out_data[0], busy[0], in_ready[0]);
        end
        @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        out_ready[0] = 1'b1;
        @(posedge clk); #1;
        vectors++;
        if (in_ready[0] !== 1'b1 || busy[0] !== 1'b0) begin
            errors++;
            $display("FAIL post_reset_ready: got ready=%b busy=%b want 1 0", in_ready[0], busy[0]);
        end
        seen = 1'b0;
        for (int i = 0; i < 8; i++) begin
            @(posedge clk); #1;
            if (out_valid[0] !== 1'b0) seen = 1'b1;
        end
        vectors++;
        if (seen !== 1'b0) begin
            errors++;
            $display("FAIL stale_output: got out_valid=1 after reset, want 0");
        end
        out_ready[0] = 1'b0;
    endtask

    task automatic test_stress(input int d, input int n);
        logic [127:0] q [$];
        logic [127:0] exp;
        int sent, recv, cyc;
        logic fin, fout;
        sent = 0; recv = 0; cyc = 0;
        @(posedge clk); #1;
        in_valid[d] = 1'($urandom_range(0, 1));
        in_data[d]  = rand128();
        in_inv[d]   = 1'($urandom_range(0, 1));
        while (recv < n && cyc < 20000) begin
            @(negedge clk);
            fin  = in_valid[d] && in_ready[d];
            fout = out_valid[d] && out_ready[d];
            if (fout) begin
                vectors++;
                if (q.size() == 0) begin
                    errors++;
                    $display("FAIL stress_extra dut%0d: got %h with no word outstanding", d, out_data[d]);
                end else begin
                    exp = q.pop_front();
                    if (out_data[d] !== exp) begin
                        errors++;
                        $display("FAIL stress_data dut%0d word%0d: got %h want %h", d, recv, out_data[d], exp);
                    end
                end
                recv++;
            end
            if (fin) begin
                q.push_back(ref_word(in_data[d], in_inv[d]));
                sent++;
            end
            @(posedge clk); #1;
            cyc++;
            if (fin || !in_valid[d]) begin
                in_valid[d] = (sent < n) ? 1'($urandom_range(0, 1)) : 1'b0;
                in_data[d]  = rand128();
                in_inv[d]   = 1'($urandom_range(0, 1));
            end
            out_ready[d] = ($urandom_range(0, 3) != 0);
        end
        vectors++;
        if (recv != n || q.size() != 0) begin
            errors++;
            $display("FAIL stress_count dut%0d: got %0d results (%0d pending), want %0d", d, recv, q.size(), n);
        end
        in_valid[d]  = 1'b0;
        out_ready[d] = 1'b0;
    endtask

    initial begin
        test_reset();
        test_forward();
        test_inverse();
        test_all_widths();
        test_backpressure();
        test_reset_mid_run();
        test_stress(0, 334);
        test_stress(1, 333);
        test_stress(2, 333);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end

endmodule
